// File: rtl/uart_rx_framer_pkg.sv
// Shared UART definitions: frame-level FSM encodings reused by the RX and TX framers.
package uart_rx_framer_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_framer_if.sv
// Byte-level output channel of the UART receiver: valid/ready byte stream plus error pulses.
interface uart_rx_framer_if;

    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        output framing_error,
        output overrun,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  framing_error,
        input  overrun,
        output data_out_ready
    );

endinterface

// File: rtl/uart_rx_framer_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs (UART line, buttons).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_framer.sv
// UART 8N1 receiver: mid-bit sampling framer with a one-byte valid/ready output holding register.
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    uart_rx_framer_if.master  rx_if
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    logic                      rx_s;
    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      armed_q, armed_d;
    logic [7:0]                data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;
    logic                      byte_done;

    // Idle-high line: preset to 1 so reset never looks like a start bit.
    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (serial_in),
        .q_o (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        armed_d   = armed_q | rx_s;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        byte_done = 1'b0;

        case (state_q)
            UART_IDLE: begin
                if (!rx_s && armed_q) begin
                    cnt_d   = '0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? UART_IDLE : UART_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UART_DATA: begin
                if (cnt_q == SYMBOL_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = UART_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UART_STOP: begin
                if (cnt_q == SYMBOL_LAST) begin
                    cnt_d   = '0;
                    state_d = UART_IDLE;
                    if (rx_s) begin
                        byte_done = 1'b1;
                    end else begin
                        // Line is still low: require a high before the next start.
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase

        if (valid_q && rx_if.data_out_ready) valid_d = 1'b0;
        if (byte_done) begin
            if (!valid_q || rx_if.data_out_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UART_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_if.data_out       = data_q;
    assign rx_if.data_out_valid = valid_q;
    assign rx_if.framing_error  = ferr_q;
    assign rx_if.overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer, run at a reduced clock/baud ratio to keep frames short.
module tb_uart_rx_framer;

    localparam int CF  = 12_500_000;
    localparam int BR  = 115_200;
    localparam int SYM = CF / BR;
    localparam int SMP = SYM / 2;
    localparam int LAT = 2 + SMP + 9 * SYM + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic serial_in = 1'b1;

    uart_rx_framer_if bus ();

    uart_rx_framer #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .rx_if     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    int valid_cycles = 0, rises = 0, handshakes = 0;
    int ferr_cycles = 0, ovr_cycles = 0;
    int last_rise_cyc = 0, start_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        serial_in = 1'b0;
        tick(SYM);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            tick(SYM);
        end
        serial_in = stop;
        tick(SYM);
        serial_in = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every accepted byte and tallies pulse cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_out_valid) begin
                valid_cycles++;
                if (!prev_valid) begin
                    rises++;
                    last_rise_cyc = cyc;
                end
            end
            if (bus.data_out_valid && bus.data_out_ready) begin
                handshakes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", int'(bus.data_out), -1);
                end else begin
                    check("data_out", int'(bus.data_out), int'(exp_q.pop_front()));
                end
            end
            if (bus.framing_error) ferr_cycles++;
            if (bus.overrun) ovr_cycles++;
        end
        prev_valid = bus.data_out_valid;
    end

    initial begin
        int vc0, r0, h0, f0, o0, lat;
        bus.data_out_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data_out", int'(bus.data_out), 0);
        check("rst_valid", int'(bus.data_out_valid), 0);
        check("rst_ferr", int'(bus.framing_error), 0);
        check("rst_ovr", int'(bus.overrun), 0);
        tick(5);

        // Single frame with ready tied high
        bus.data_out_ready = 1'b1;
        vc0 = valid_cycles; h0 = handshakes;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        tick(10);
        check("t1_valid_cycles", valid_cycles - vc0, 1);
        check("t1_handshakes", handshakes - h0, 1);
        lat = last_rise_cyc - start_cyc;
        n_chk++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            n_fail++;
            $display("FAIL t1_latency: got %0d cycles, expected %0d +/-1", lat, LAT);
        end

        // Back-to-back with ready low: second byte is an overrun
        bus.data_out_ready = 1'b0;
        o0 = ovr_cycles;
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        tick(5);
        @(negedge clk);
        check("t2_overrun_pulses", ovr_cycles - o0, 1);
        check("t2_data_held", int'(bus.data_out), 8'h41);
        check("t2_valid_held", int'(bus.data_out_valid), 1);
        bus.data_out_ready = 1'b1;
        tick(3);
        check("t2_scoreboard_empty", exp_q.size(), 0);

        // Short low glitch is a false start
        f0 = ferr_cycles; r0 = rises;
        serial_in = 1'b0;
        tick(30);
        serial_in = 1'b1;
        tick(2 * SYM);
        check("t3_no_ferr", ferr_cycles - f0, 0);
        check("t3_no_valid", rises - r0, 0);

        // Bad stop bit, then a good frame
        f0 = ferr_cycles; r0 = rises;
        send_frame(8'hC3, 1'b0);
        tick(5);
        @(negedge clk);
        check("t4_ferr_pulses", ferr_cycles - f0, 1);
        check("t4_no_valid", rises - r0, 0);
        check("t4_valid_low", int'(bus.data_out_valid), 0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        tick(5);
        check("t4_scoreboard_empty", exp_q.size(), 0);

        // Reset mid-frame
        f0 = ferr_cycles; o0 = ovr_cycles; r0 = rises;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(5 * SYM + SMP);
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
        join
        tick(5);
        @(negedge clk);
        check("t5_data_zero", int'(bus.data_out), 0);
        check("t5_valid_zero", int'(bus.data_out_valid), 0);
        check("t5_no_pulses", (ferr_cycles - f0) + (ovr_cycles - o0), 0);
        check("t5_no_valid", rises - r0, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        tick(5);
        check("t5_scoreboard_empty", exp_q.size(), 0);

        // Ready pulsed in the cycle the second byte completes
        bus.data_out_ready = 1'b0;
        o0 = ovr_cycles; r0 = rises;
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h66);
        send_frame(8'h33, 1'b1);
        tick(5);
        fork
            send_frame(8'h66, 1'b1);
            begin
                tick(2 + SMP + 9 * SYM);
                bus.data_out_ready = 1'b1;
                tick(1);
                bus.data_out_ready = 1'b0;
            end
        join
        @(negedge clk);
        check("t6_valid_kept", int'(bus.data_out_valid), 1);
        check("t6_no_overrun", ovr_cycles - o0, 0);
        check("t6_single_rise", rises - r0, 1);
        check("t6_first_popped", exp_q.size(), 1);
        bus.data_out_ready = 1'b1;
        tick(3);
        check("t6_scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, meaning the serial bit rate in bits/s.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port serial_in, input, 1, the asynchronous UART line (board FPGA_SERIAL_RX), which idles high.
REQ-006 SHALL have port data_out, output, 8, the received byte.
REQ-007 SHALL have port data_out_valid, output, 1, which is high while data_out holds an unconsumed byte.
REQ-008 SHALL have port data_out_ready, input, 1, the consumer accept signal.
REQ-009 SHALL have port framing_error, output, 1, a 1-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun, output, 1, a 1-cycle pulse when a completed byte is dropped.

Function
REQ-011 SHALL pass serial_in through a 2-flop synchronizer; all framing logic uses only the synchronized bit (rx_s).
REQ-012 SHALL derive SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE by integer division, and SAMPLE_TIME = SYMBOL_EDGE_TIME/2.
REQ-013 SHALL size the bit-timing counter to clog2(SYMBOL_EDGE_TIME) bits; the counter never wraps past SYMBOL_EDGE_TIME-1.
REQ-014 SHALL implement states IDLE, START, DATA and STOP.
REQ-015 IDLE: rx_s==0 SHALL clear the counter and enter START.
REQ-016 START: at count==SAMPLE_TIME-1 the block SHALL sample rx_s; a 0 enters DATA, and a 1 is a false start that returns to IDLE with no output.
REQ-017 DATA: SHALL sample rx_s every SYMBOL_EDGE_TIME cycles after the start-bit sample and shift it in LSB first, using a 3-bit bit index.
REQ-018 DATA: after the 8th sample the block SHALL enter STOP.
REQ-019 STOP: SHALL sample rx_s SYMBOL_EDGE_TIME cycles after bit 7; after the sample it returns to IDLE the same cycle, so back-to-back frames are received.
REQ-020 A stop bit of 1 SHALL complete the byte.
REQ-021 A stop bit of 0 SHALL discard the byte, pulse framing_error for 1 cycle and return to IDLE; no new start is accepted until rx_s has been seen high for 1 cycle.
REQ-022 On a completed byte with data_out_valid==0, data_out SHALL load the shift register and data_out_valid SHALL rise on the next clk edge.
REQ-023 SHALL hold data_out and data_out_valid stable until a cycle with data_out_valid && data_out_ready; data_out_valid falls on the next edge.
REQ-024 On a completed byte while data_out_valid==1 && !data_out_ready, the block SHALL drop the new byte, pulse overrun, and leave data_out unchanged.
REQ-025 On a completed byte coinciding with data_out_valid && data_out_ready, the block SHALL load the new byte, keep data_out_valid high and not pulse overrun.
REQ-026 Latency from the serial_in falling edge to data_out_valid high SHALL be 2 + SAMPLE_TIME + 9*SYMBOL_EDGE_TIME + 1 cycles (±1).

Reset
REQ-027 rst SHALL force IDLE, zero the counter, bit index and shift register, and set data_out=0, data_out_valid=0, framing_error=0, overrun=0.
REQ-028 rst SHALL preset the synchronizer flops to 1.
REQ-029 rst asserted mid-frame SHALL abandon the frame with no output pulses; reception restarts on the next falling edge after rst deasserts.
REQ-030 rst SHALL take priority over all other events in the same cycle.

Structure
REQ-031 State encodings SHALL reside in a shared uart definitions include, so the future uart_tx_framer reuses them.
REQ-032 SYMBOL_EDGE_TIME and SAMPLE_TIME SHALL be local to the block.
REQ-033 The synchronizer SHALL be a separate sub-module, sync_2ff, reusable for the button inputs.

Verification (CLOCK_FREQ=125e6, BAUD=115200, so SYMBOL_EDGE_TIME=1085 and SAMPLE_TIME=542)
REQ-034 Frame 0x5A, ready tied high -> data_out=0x5A with valid high for exactly 1 cycle, about 10,310 cycles after the start edge.
REQ-035 Bytes 0x41 and 0x42 sent back-to-back with ready low, then ready raised -> data_out=0x41 retained and one overrun pulse for 0x42.
REQ-036 A 300-cycle low glitch on an idle line -> no valid and no framing_error; the block is back in IDLE.
REQ-037 Frame 0xC3 with stop bit 0 -> one framing_error pulse, valid stays 0; the next good frame 0x11 is received correctly.
REQ-038 rst pulsed at bit 4 of 0xFF -> all outputs 0, no valid; the following frame 0x81 is received.
REQ-039 Ready pulsed in the same cycle the second byte completes -> the second byte is loaded, valid stays high and there is no overrun.
